// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit
// CPU datapath, sharing one memory port between instruction fetch and
// load/store. Memory handshake tolerates wait states and raises a sticky
// fault once a request waits MEM_WAIT_MAX cycles without mem_ready.
//
// Optional feature: define MULTICYCLE_PERF_CNT_EN to add the saturating
// performance counters cyc_cnt (busy cycles) and ret_cnt (retired
// instructions). Without the macro those ports and their logic are absent.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15
`ifdef MULTICYCLE_PERF_CNT_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] inst,
  input  logic        br_mux,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [3:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        br_sel,
  output logic        reg_en,
  output logic        lr_en,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
`ifdef MULTICYCLE_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt
  , output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  // Sequencer states (encodings are visible on the debug state port)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;
  localparam logic [2:0] S_FAULT  = 3'd7;

  // Opcodes outside the ALU range (0000-0111)
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b1010;
  localparam logic [3:0] OP_BL    = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_RET   = 4'b1101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // PC source and write-back source selects
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_LR  = 2'b11;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_at_max;
  logic              enter_mem_phase;
  logic [3:0]        opcode;
  logic              is_alu;
  logic              unused_inst_bits;

  assign opcode           = inst[15:12];
  assign is_alu           = ~opcode[3];
  assign unused_inst_bits = ^inst[11:0];
  assign state            = state_r;
  assign wait_at_max      = (wait_cnt == WAIT_W'(MEM_WAIT_MAX));
  assign enter_mem_phase  = (state_nxt != state_r) &&
                            ((state_nxt == S_FETCH) || (state_nxt == S_MEM));

  // Next-state selection
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)        state_nxt = S_DECODE;
        else if (wait_at_max) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu) begin
          state_nxt = S_WB;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_nxt = S_MEM;
            OP_HALT:           state_nxt = S_HALTED;
            default:           state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready)        state_nxt = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        else if (wait_at_max) state_nxt = S_FAULT;
      end
      S_WB: begin
        state_nxt = S_FETCH;
      end
      S_HALTED: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt;
  end

  // Memory wait counter: restarts per request, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mem_ready || enter_mem_phase) begin
      wait_cnt <= '0;
    end else if (mem_req && !wait_at_max) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Datapath controls and strobes decoded from state, opcode and handshake
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_en   = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = PC_INC;
    alu_op  = '0;
    wb_sel  = WB_ALU;
    br_sel  = 1'b0;
    reg_en  = 1'b0;
    lr_en   = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en  = 1'b1;
          pc_en  = 1'b1;
          pc_sel = PC_INC;
        end
      end
      S_EXEC: begin
        if (is_alu) alu_op = opcode;
        case (opcode)
          OP_BR: begin
            br_sel = br_mux;
            pc_en  = br_mux;
            pc_sel = PC_BR;
          end
          OP_BL: begin
            lr_en  = 1'b1;
            pc_en  = 1'b1;
            pc_sel = PC_JMP;
          end
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_sel = PC_JMP;
          end
          OP_RET: begin
            pc_en  = 1'b1;
            pc_sel = PC_LR;
          end
          default: begin
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
      end
      S_WB: begin
        reg_en = 1'b1;
        if (is_alu) alu_op = opcode;
        if (opcode == OP_LOAD) wb_sel = WB_MEM;
      end
      S_HALTED: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic busy;
  logic retire;

  assign busy   = (state_r != S_IDLE) && (state_r != S_HALTED) && (state_r != S_FAULT);
  // Completion is the last EXEC/MEM/WB cycle heading to FETCH, or HALT's EXEC
  assign retire = ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB)) &&
                  ((state_nxt == S_FETCH) || (state_nxt == S_HALTED));

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (busy && (cyc_cnt != '1))   cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (retire && (ret_cnt != '1)) ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
